display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_pkg.sv | 11 +
 rtl/tick_generator.sv | 27 ++
 rtl/display_scan_controller.sv | 117 +++++++++++
 tb/tb_display_scan_controller.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the 8-digit multiplexed hex display.
package display_pkg;

   localparam int NUM_DIGITS           = 8;
   localparam int DIGIT_W              = 4;
   localparam int REFRESH_DIV_DEFAULT  = 100000;
   localparam int BLINK_FRAMES_DEFAULT = 64;

   typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/tick_generator.sv
// Free-running prescaler: tick is high while the count holds DIV-1, once every DIV cycles.
module tick_generator #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/display_scan_controller.sv
// Scans eight hex digits, committing new values only between frames, with
// leading-zero blanking and per-digit blinking applied to the anode enables.
module display_scan_controller
   import display_pkg::*;
#(
   parameter int REFRESH_DIV  = REFRESH_DIV_DEFAULT,
   parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] digs_in,
   input  logic        load,
   input  logic [7:0]  digit_en,
   input  logic        blank_lz,
   input  logic [7:0]  blink_mask,
   output logic [31:0] digs,
   output logic [2:0]  counter,
   output logic [7:0]  an_on,
   output logic        frame_start,
   output logic        load_ack
);

   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic          tick;
   logic          boundary;
   logic [31:0]   pend_val;
   logic          pend_flag;
   logic [FW-1:0] frame_cnt;
   logic          blink_phase;
   logic [7:0]    lz;
   logic          all_zero;
   digit_t        cur_digit;

   tick_generator #(
      .DIV (REFRESH_DIV)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   assign boundary = tick && (counter == 3'd7);

   // Digit scan position and frame-boundary pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter     <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= boundary;
         if (tick) begin
            counter <= counter + 3'd1;
         end
      end
   end

   // A load on the boundary cycle bypasses pending so it lands in this frame swap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digs      <= '0;
         pend_val  <= '0;
         pend_flag <= 1'b0;
         load_ack  <= 1'b0;
      end else begin
         load_ack <= boundary && (load || pend_flag);
         if (boundary) begin
            if (load) begin
               digs <= digs_in;
            end else if (pend_flag) begin
               digs <= pend_val;
            end
            pend_flag <= 1'b0;
         end else if (load) begin
            pend_val  <= digs_in;
            pend_flag <= 1'b1;
         end
      end
   end

   // Blink phase flips every BLINK_FRAMES frames.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (boundary) begin
         if (frame_cnt == FRAME_LAST) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   // Digit i is a leading zero when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      lz        = '0;
      all_zero  = 1'b1;
      cur_digit = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         cur_digit = digs[i*DIGIT_W +: DIGIT_W];
         all_zero  = all_zero & (cur_digit == '0);
         lz[i]     = blank_lz & all_zero;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an_on <= '0;
      end else begin
         an_on <= digit_en & ~lz & ~(blink_mask & {NUM_DIGITS{blink_phase}});
      end
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed test of display_scan_controller with REFRESH_DIV=4, BLINK_FRAMES=2.
module tb_display_scan_controller;

   logic        clk;
   logic        reset_n;
   logic [31:0] digs_in;
   logic        load;
   logic [7:0]  digit_en;
   logic        blank_lz;
   logic [7:0]  blink_mask;
   logic [31:0] digs;
   logic [2:0]  counter;
   logic [7:0]  an_on;
   logic        frame_start;
   logic        load_ack;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   display_scan_controller #(
      .REFRESH_DIV  (4),
      .BLINK_FRAMES (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .digs_in     (digs_in),
      .load        (load),
      .digit_en    (digit_en),
      .blank_lz    (blank_lz),
      .blink_mask  (blink_mask),
      .digs        (digs),
      .counter     (counter),
      .an_on       (an_on),
      .frame_start (frame_start),
      .load_ack    (load_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // One clock cycle; cyc counts posedges since reset release.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic goto_counter(input int c);
      int guard = 0;
      while (((cyc / 4) % 8) != c && guard < 64) begin
         step();
         guard++;
      end
      vectors++;
      if (((cyc / 4) % 8) != c) begin
         errors++;
         $display("[TB] FAIL goto_counter: reached %0d, wanted %0d", (cyc / 4) % 8, c);
      end
   endtask

   // Parks the bench on the boundary cycle (tick with counter==7).
   task automatic goto_boundary_cycle();
      int guard = 0;
      while ((cyc % 32) != 31 && guard < 64) begin
         step();
         guard++;
      end
      vectors++;
      if ((cyc % 32) != 31) begin
         errors++;
         $display("[TB] FAIL goto_boundary: cycle phase %0d, wanted 31", cyc % 32);
      end
   endtask

   task automatic load_on_boundary(input logic [31:0] val);
      goto_boundary_cycle();
      load    = 1'b1;
      digs_in = val;
      step();
      load    = 1'b0;
      digs_in = '0;
      vectors++;
      if (digs !== val) begin
         errors++;
         $display("[TB] FAIL boundary_load_digs: got %h, expected %h", digs, val);
      end
      vectors++;
      if (load_ack !== 1'b1 || frame_start !== 1'b1) begin
         errors++;
         $display("[TB] FAIL boundary_load_pulses: load_ack=%b frame_start=%b, expected 1/1", load_ack, frame_start);
      end
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      load       = 1'b0;
      digs_in    = '0;
      digit_en   = '0;
      blank_lz   = 1'b0;
      blink_mask = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if (digs !== 32'h0 || counter !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset_digs_counter: digs=%h counter=%0d, expected 0/0", digs, counter);
      end
      vectors++;
      if (an_on !== 8'h00 || frame_start !== 1'b0 || load_ack !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: an_on=%h fs=%b ack=%b, expected 00/0/0", an_on, frame_start, load_ack);
      end
      reset_n = 1'b1;
      cyc     = 0;
   endtask

   task automatic test_scan();
      for (int k = 0; k < 40; k++) begin
         step();
         vectors++;
         if (counter !== 3'((cyc / 4) % 8)) begin
            errors++;
            $display("[TB] FAIL scan_counter: cycle %0d got %0d, expected %0d", cyc, counter, (cyc / 4) % 8);
         end
         vectors++;
         if (frame_start !== ((cyc % 32) == 0)) begin
            errors++;
            $display("[TB] FAIL scan_frame_start: cycle %0d got %b, expected %b", cyc, frame_start, (cyc % 32) == 0);
         end
      end
      vectors++;
      if (digs !== 32'h0 || load_ack !== 1'b0) begin
         errors++;
         $display("[TB] FAIL scan_idle: digs=%h ack=%b, expected 0/0", digs, load_ack);
      end
   endtask

   task automatic test_load_aligned();
      goto_counter(3);
      load    = 1'b1;
      digs_in = 32'h1234_5678;
      step();
      load    = 1'b0;
      digs_in = '0;
      for (int g = 0; g < 64; g++) begin
         if ((cyc % 32) == 0) break;
         vectors++;
         if (digs !== 32'h0 || load_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL aligned_hold: cycle %0d digs=%h ack=%b, expected 0/0", cyc, digs, load_ack);
         end
         step();
      end
      vectors++;
      if (digs !== 32'h1234_5678) begin
         errors++;
         $display("[TB] FAIL aligned_commit: got %h, expected 12345678", digs);
      end
      vectors++;
      if (load_ack !== 1'b1 || frame_start !== 1'b1) begin
         errors++;
         $display("[TB] FAIL aligned_pulses: ack=%b fs=%b, expected 1/1", load_ack, frame_start);
      end
      step();
      vectors++;
      if (load_ack !== 1'b0 || frame_start !== 1'b0) begin
         errors++;
         $display("[TB] FAIL aligned_pulse_width: ack=%b fs=%b, expected 0/0", load_ack, frame_start);
      end
   endtask

   task automatic test_latest_wins();
      goto_counter(2);
      load    = 1'b1;
      digs_in = 32'hAAAA_AAAA;
      step();
      goto_counter(4);
      load    = 1'b1;
      digs_in = 32'hBBBB_BBBB;
      step();
      load    = 1'b0;
      digs_in = '0;
      vectors++;
      if (digs !== 32'h1234_5678) begin
         errors++;
         $display("[TB] FAIL latest_hold: got %h, expected 12345678", digs);
      end
      goto_boundary_cycle();
      step();
      vectors++;
      if (digs !== 32'hBBBB_BBBB || load_ack !== 1'b1) begin
         errors++;
         $display("[TB] FAIL latest_commit: digs=%h ack=%b, expected bbbbbbbb/1", digs, load_ack);
      end
      load_on_boundary(32'hCCCC_CCCC);
      goto_boundary_cycle();
      step();
      vectors++;
      if (load_ack !== 1'b0 || frame_start !== 1'b1 || digs !== 32'hCCCC_CCCC) begin
         errors++;
         $display("[TB] FAIL no_stale_pending: ack=%b fs=%b digs=%h, expected 0/1/cccccccc", load_ack, frame_start, digs);
      end
   endtask

   task automatic test_leading_zero();
      blank_lz   = 1'b1;
      digit_en   = 8'hFF;
      blink_mask = 8'h00;
      load_on_boundary(32'h0000_0042);
      step();
      step();
      vectors++;
      if (an_on !== 8'h03) begin
         errors++;
         $display("[TB] FAIL lz_0042: got %h, expected 03", an_on);
      end
      load_on_boundary(32'h0000_0000);
      step();
      step();
      vectors++;
      if (an_on !== 8'h01) begin
         errors++;
         $display("[TB] FAIL lz_zero: got %h, expected 01", an_on);
      end
      blank_lz = 1'b0;
      step();
      vectors++;
      if (an_on !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL lz_off: got %h, expected ff", an_on);
      end
      digit_en = 8'h0F;
      step();
      vectors++;
      if (an_on !== 8'h0F) begin
         errors++;
         $display("[TB] FAIL digit_en_mask: got %h, expected 0f", an_on);
      end
      digit_en = 8'hFF;
   endtask

   // Blink phase after n frame boundaries is (n/2)%2; checked mid-frame.
   task automatic test_blink();
      logic [7:0] exp_an;
      blink_mask = 8'h80;
      blank_lz   = 1'b0;
      load_on_boundary(32'h8000_0000);
      for (int f = 0; f < 6; f++) begin
         goto_counter(4);
         exp_an = (((cyc / 32) / 2) % 2 == 1) ? 8'h7F : 8'hFF;
         vectors++;
         if (an_on !== exp_an) begin
            errors++;
            $display("[TB] FAIL blink_frame%0d: got %h, expected %h", f, an_on, exp_an);
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      goto_counter(2);
      load    = 1'b1;
      digs_in = 32'hDDDD_DDDD;
      step();
      load    = 1'b0;
      digs_in = '0;
      goto_counter(5);
      reset_n = 1'b0;
      #1;
      vectors++;
      if (digs !== 32'h0 || counter !== 3'd0 || an_on !== 8'h00) begin
         errors++;
         $display("[TB] FAIL midreset_async: digs=%h counter=%0d an_on=%h, expected 0/0/00", digs, counter, an_on);
      end
      vectors++;
      if (frame_start !== 1'b0 || load_ack !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_pulses: fs=%b ack=%b, expected 0/0", frame_start, load_ack);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      cyc     = 0;
      repeat (3) step();
      vectors++;
      if (counter !== 3'd0 || an_on !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL restart_hold: counter=%0d an_on=%h, expected 0/ff", counter, an_on);
      end
      step();
      vectors++;
      if (counter !== 3'd1) begin
         errors++;
         $display("[TB] FAIL restart_first_tick: got %0d, expected 1", counter);
      end
      goto_boundary_cycle();
      step();
      vectors++;
      if (frame_start !== 1'b1 || load_ack !== 1'b0 || digs !== 32'h0) begin
         errors++;
         $display("[TB] FAIL discarded_pending: fs=%b ack=%b digs=%h, expected 1/0/0", frame_start, load_ack, digs);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_load_aligned();
      test_latest_wins();
      test_leading_zero();
      test_blink();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
